apb_master_bridge: RTL

//  APB initiator: converts a valid/ready request stream into single APB3 transfers to

---
 rtl/apb_master_bridge.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB3 initiator: takes one valid/ready request at a time, runs a SETUP/ACCESS transfer,
// and returns read data/error (or a timeout abort) on a valid/ready response channel.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr,
  input  logic                      req_write,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_tout,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

  // Handshakes: a request transfers on the edge where req_valid & req_ready are both 1,
  // a response on the edge where rsp_valid & rsp_ready are both 1; the side raising
  // valid holds it and its payload stable until that edge.

  localparam logic [15:0] TOUT_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  state_t                    state, next_state;
  logic [15:0]               wait_cnt, wait_cnt_d;
  logic                      timeout_hit;
  logic                      req_ready_d, rsp_valid_d, rsp_err_d, rsp_tout_d;
  logic                      psel_d, penable_d, pwrite_d;
  logic [31:0]               rsp_rdata_d, pwdata_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_d;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];
  assign timeout_hit      = (TIMEOUT_CYCLES != 0) && (wait_cnt == TOUT_LAST);
  assign dbg_state        = state;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= IDLE;
      wait_cnt  <= 16'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      rsp_tout  <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= 32'd0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      state     <= next_state;
      wait_cnt  <= wait_cnt_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      rsp_tout  <= rsp_tout_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PWRITE    <= pwrite_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Computes the next value of every registered output so all outputs leave flops.
  always_comb begin
    wait_cnt_d  = wait_cnt;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    rsp_tout_d  = rsp_tout;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    pwrite_d    = PWRITE;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    req_ready_d = (next_state == IDLE);
    case (state)
      IDLE: begin
        if (req_valid) begin
          paddr_d   = {req_addr[APB_ADDR_WIDTH-1:2], 2'b00};
          pwdata_d  = req_wdata;
          pwrite_d  = req_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      SETUP: begin
        psel_d     = 1'b1;
        penable_d  = 1'b1;
        wait_cnt_d = 16'd0;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d = PWRITE ? 32'd0 : PRDATA;
          rsp_err_d   = PSLVERR;
          rsp_tout_d  = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          rsp_tout_d  = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end else if (wait_cnt != 16'hFFFF) begin
          wait_cnt_d = wait_cnt + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
